// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the button debounce bank.
//   db_state_e : per-channel debounce FSM state (2-bit)
//   db_w()     : stable-time counter width for a given DEBOUNCE_CYCLES
//   lg_w()     : long-press counter width for a given LONG_CYCLES
package button_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } db_state_e;

  // Stable counter never needs to exceed DEBOUNCE_CYCLES-1.
  function automatic int db_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  // Long counter saturates at LONG_CYCLES-1.
  function automatic int lg_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM with stable-time
// counter, long-press timer, registered rise/fall/long pulses and wrapping
// counters of debounced presses and raw synchronised rising edges.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   button                raw asynchronous input (active-high)
//   cnt_clr               synchronous clear of both counters (wins over +1)
//   db_level              debounced level
//   rise_pulse/fall_pulse one-cycle pulses on db_level edges
//   long_press            one-cycle pulse once a press has been held long enough
//   press_count           debounced rising edges, wraps at 2^CNT_W
//   noisy_count           synchronised raw rising edges, wraps at 2^CNT_W
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             button,
  input  logic             cnt_clr,
  output logic             db_level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             long_press,
  output logic [CNT_W-1:0] press_count,
  output logic [CNT_W-1:0] noisy_count
);

  localparam int DB_W = db_w(DEBOUNCE_CYCLES);
  localparam int LG_W = lg_w(LONG_CYCLES);
  // The counter is cleared on entry to a WAIT state, so the level is accepted
  // on the edge where it would step from DEBOUNCE_CYCLES-2 to DEBOUNCE_CYCLES-1.
  localparam logic [DB_W-1:0] STABLE_LAST = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [LG_W-1:0] LONG_LAST   = LG_W'(LONG_CYCLES - 1);

  logic             sync_q;
  logic             s;
  logic             s_prev;
  logic             raw_rise;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [DB_W-1:0]  stable_cnt;
  logic [LG_W-1:0]  long_cnt;
  logic             long_fired;
  logic             rise_d;
  logic             fall_d;
  logic             long_d;

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= button;
      s      <= sync_q;
      s_prev <= s;
    end
  end

  assign raw_rise = s & ~s_prev;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_LOW;
    else          state_q <= state_d;
  end

  // FSM next state
  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOW:       if (s) state_d = ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (!s) state_d = ST_LOW;
                    else if (stable_cnt == STABLE_LAST) state_d = ST_HIGH;
      ST_HIGH:      if (!s) state_d = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (s) state_d = ST_HIGH;
                    else if (stable_cnt == STABLE_LAST) state_d = ST_LOW;
      default:      state_d = ST_LOW;
    endcase
  end

  // FSM outputs
  always_comb begin
    db_level = (state_q == ST_HIGH) || (state_q == ST_WAIT_LOW);
    rise_d   = (state_q == ST_WAIT_HIGH) && (state_d == ST_HIGH);
    fall_d   = (state_q == ST_WAIT_LOW)  && (state_d == ST_LOW);
    long_d   = (state_q == ST_HIGH) && (long_cnt == LONG_LAST) && !long_fired;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      long_press <= 1'b0;
    end else begin
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      long_press <= long_d;
    end
  end

  // Stable-time counter: runs only while staying in a WAIT state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt <= '0;
    end else if (((state_q == ST_WAIT_HIGH) || (state_q == ST_WAIT_LOW)) &&
                 (state_d == state_q)) begin
      stable_cnt <= stable_cnt + 1'b1;
    end else begin
      stable_cnt <= '0;
    end
  end

  // Long-press timer: saturates, and the fired flag keeps the pulse single
  // until the channel leaves HIGH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      long_cnt   <= '0;
      long_fired <= 1'b0;
    end else if (state_q != ST_HIGH) begin
      long_cnt   <= '0;
      long_fired <= 1'b0;
    end else begin
      if (long_cnt != LONG_LAST) long_cnt <= long_cnt + 1'b1;
      if (long_d)                long_fired <= 1'b1;
    end
  end

  // Event counters; clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_count <= '0;
      noisy_count <= '0;
    end else if (cnt_clr) begin
      press_count <= '0;
      noisy_count <= '0;
    end else begin
      if (rise_pulse) press_count <= press_count + 1'b1;
      if (raw_rise)   noisy_count <= noisy_count + 1'b1;
    end
  end

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of N_CH independent button conditioning channels.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   button_in[N_CH]          raw button inputs
//   cnt_clr                  synchronous clear of all counters
//   db_level/rise_pulse/fall_pulse/long_press[N_CH]  per-channel outputs
//   press_count/noisy_count  per-channel counters, channel k at [k*CNT_W +: CNT_W]
module button_debounce_bank
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int CNT_W           = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       button_in,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       db_level,
  output logic [N_CH-1:0]       rise_pulse,
  output logic [N_CH-1:0]       fall_pulse,
  output logic [N_CH-1:0]       long_press,
  output logic [N_CH*CNT_W-1:0] press_count,
  output logic [N_CH*CNT_W-1:0] noisy_count
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .CNT_W           (CNT_W)
    ) u_channel (
      .clk         (clk),
      .reset_n     (reset_n),
      .button      (button_in[k]),
      .cnt_clr     (cnt_clr),
      .db_level    (db_level[k]),
      .rise_pulse  (rise_pulse[k]),
      .fall_pulse  (fall_pulse[k]),
      .long_press  (long_press[k]),
      .press_count (press_count[k*CNT_W +: CNT_W]),
      .noisy_count (noisy_count[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Scoreboard bench: the driver advances a behavioural model (run lengths of
// the synchronised level, age of a steady press) every cycle and queues the
// expected outputs; a monitor pops and compares after every clock edge.
module tb_button_debounce_bank;

  localparam int N  = 2;
  localparam int DB = 8;
  localparam int LG = 32;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      button_in = '0;
  logic              cnt_clr = 1'b0;
  logic [N-1:0]      db_level, rise_pulse, fall_pulse, long_press;
  logic [N*CW-1:0]   press_count, noisy_count;

  button_debounce_bank #(
    .N_CH(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .button_in(button_in), .cnt_clr(cnt_clr),
    .db_level(db_level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .long_press(long_press), .press_count(press_count), .noisy_count(noisy_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]    lvl;
    logic [N-1:0]    rise;
    logic [N-1:0]    fall;
    logic [N-1:0]    lng;
    logic [N*CW-1:0] press;
    logic [N*CW-1:0] noisy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_r1[N], m_s[N], m_sp[N];   // raw sampled 1 and 2 edges ago, and 3
  int m_db[N], m_run[N], m_age[N];
  int m_rise[N], m_fall[N], m_long[N];
  int m_press[N], m_noisy[N];
  bit clr_on_rise = 1'b0;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_r1[c] = 0; m_s[c] = 0; m_sp[c] = 0;
      m_db[c] = 0; m_run[c] = 0; m_age[c] = -1;
      m_rise[c] = 0; m_fall[c] = 0; m_long[c] = 0;
      m_press[c] = 0; m_noisy[c] = 0;
    end
  endfunction

  // One clock edge: a level is accepted once the synchronised input has
  // disagreed with it for DB consecutive samples; long fires when a steady
  // press has aged LG cycles.
  function automatic void model_edge(input logic [N-1:0] btn, input logic clr);
    for (int c = 0; c < N; c++) begin
      int sb;
      sb = m_s[c];
      if (clr) m_press[c] = 0;
      else if (m_rise[c] != 0) m_press[c] = (m_press[c] + 1) % (1 << CW);
      if (clr) m_noisy[c] = 0;
      else if (sb == 1 && m_sp[c] == 0) m_noisy[c] = (m_noisy[c] + 1) % (1 << CW);
      m_long[c] = (m_age[c] == LG - 1) ? 1 : 0;
      m_rise[c] = 0;
      m_fall[c] = 0;
      if (sb != m_db[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_db[c]  = sb;
          m_run[c] = 0;
          if (sb == 1) m_rise[c] = 1; else m_fall[c] = 1;
        end
      end else begin
        m_run[c] = 0;
      end
      m_age[c] = (m_db[c] == 1 && m_run[c] == 0) ? m_age[c] + 1 : -1;
      m_sp[c] = sb;
      m_s[c]  = m_r1[c];
      m_r1[c] = int'(btn[c]);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int c = 0; c < N; c++) begin
      e.lvl[c]  = (m_db[c] != 0);
      e.rise[c] = (m_rise[c] != 0);
      e.fall[c] = (m_fall[c] != 0);
      e.lng[c]  = (m_long[c] != 0);
      e.press[c*CW +: CW] = CW'(m_press[c]);
      e.noisy[c*CW +: CW] = CW'(m_noisy[c]);
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("db_level", db_level, e.lvl);
      check("rise_fall_long", {rise_pulse, fall_pulse, long_press}, {e.rise, e.fall, e.lng});
      check("press_count", press_count, e.press);
      check("noisy_count", noisy_count, e.noisy);
    end
  end

  // ---------------- driver ----------------
  int tcount;
  int first_rise[N], first_fall[N], first_long[N], n_rise[N], n_long[N];

  task automatic clear_stats();
    tcount = 0;
    for (int c = 0; c < N; c++) begin
      first_rise[c] = 0; first_fall[c] = 0; first_long[c] = 0;
      n_rise[c] = 0; n_long[c] = 0;
    end
  endtask

  // Called at a falling edge: drive, predict the next rising edge, wait.
  task automatic step(input logic [N-1:0] btn, input logic clr);
    logic clr_now;
    clr_now   = clr | (clr_on_rise & (m_rise[0] != 0));
    button_in = btn;
    cnt_clr   = clr_now;
    if (reset_n) begin
      model_edge(btn, clr_now);
      q.push_back(model_out());
    end
    @(negedge clk);
    tcount++;
    for (int c = 0; c < N; c++) begin
      if (rise_pulse[c]) begin n_rise[c]++; if (first_rise[c] == 0) first_rise[c] = tcount; end
      if (fall_pulse[c] && first_fall[c] == 0) first_fall[c] = tcount;
      if (long_press[c]) begin n_long[c]++; if (first_long[c] == 0) first_long[c] = tcount; end
    end
  endtask

  task automatic hold(input logic [N-1:0] btn, input int n);
    for (int i = 0; i < n; i++) step(btn, 1'b0);
  endtask

  task automatic do_reset(input logic [N-1:0] btn);
    #2;
    reset_n = 1'b0;
    q.delete();
    #1;
    check("reset_outputs_zero",
          {db_level, rise_pulse, fall_pulse, long_press, press_count, noisy_count}, 64'd0);
    model_reset();
    hold(btn, 2);
    reset_n = 1'b1;
  endtask

  initial begin
    int           rem[N];
    logic [N-1:0] lvl;

    model_reset();
    @(negedge clk);
    #1;
    check("reset_state",
          {db_level, rise_pulse, fall_pulse, long_press, press_count, noisy_count}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean press on ch0, then release
    clear_stats();
    hold(2'b01, 20);
    check("clean_rise_latency", first_rise[0], 10);
    check("clean_no_long", n_long[0], 0);
    check("clean_press_count", press_count[3:0], 1);
    check("clean_noisy_count", noisy_count[3:0], 1);
    clear_stats();
    hold(2'b00, 20);
    check("clean_fall_latency", first_fall[0], 10);

    // Bounce on ch1 ending high
    clear_stats();
    hold(2'b10, 3); hold(2'b00, 3); hold(2'b10, 3); hold(2'b00, 3); hold(2'b10, 18);
    check("bounce_high_rises", n_rise[1], 1);
    check("bounce_high_press", press_count[7:4], 1);
    check("bounce_high_noisy", noisy_count[7:4], 3);
    hold(2'b00, 15);
    // Bounce on ch1 ending low
    clear_stats();
    hold(2'b10, 3); hold(2'b00, 3); hold(2'b10, 3); hold(2'b00, 15);
    check("bounce_low_rises", n_rise[1], 0);
    check("bounce_low_level", db_level[1], 0);

    // Long press on ch0
    clear_stats();
    hold(2'b01, 50);
    check("long_delay", first_long[0] - first_rise[0], LG);
    check("long_single", n_long[0], 1);
    hold(2'b00, 15);

    // Counter wrap and clear priority
    step(2'b00, 1'b1);
    for (int i = 0; i < 17; i++) begin
      hold(2'b01, 12);
      hold(2'b00, 12);
    end
    check("press_wrap", press_count[3:0], 1);
    clr_on_rise = 1'b1;
    hold(2'b01, 12);
    clr_on_rise = 1'b0;
    hold(2'b00, 12);
    check("press_clr_wins", press_count[3:0], 0);

    // Simultaneous press on both channels
    clear_stats();
    hold(2'b11, 15);
    check("simul_rise_ch0", first_rise[0], 10);
    check("simul_rise_same_cycle", first_rise[1], first_rise[0]);
    hold(2'b00, 15);

    // Reset in WAIT_HIGH, then in HIGH, with the input held high
    hold(2'b01, 5);
    do_reset(2'b01);
    clear_stats();
    hold(2'b01, 15);
    check("reset_wait_high_relatency", first_rise[0], 10);
    do_reset(2'b01);
    clear_stats();
    hold(2'b01, 15);
    check("reset_high_relatency", first_rise[0], 10);
    hold(2'b00, 15);

    // Randomised segments per channel
    for (int c = 0; c < N; c++) rem[c] = 0;
    lvl = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 60))
                                                : int'($urandom_range(1, 12));
        end
        rem[c]--;
      end
      step(lvl, ($urandom_range(0, 63) == 0));
    end
    hold(2'b00, 20);
    check("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
